// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encoding, direction codes and byte helper
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Pull byte idx out of a packed bus zero-extended to the 8-requester maximum.
  function automatic logic [7:0] get_byte(input logic [63:0] bus, input logic [2:0] idx);
    return bus[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and memory-side signal bundle for the arbiter
interface mem_bus_arbiter_if #(
  parameter int NREQ = 3
);
  import mem_arb_pkg::*;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ-1:0]   req_lock;
  logic [8*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [7:0]        rdata;
  logic              mem_en;
  logic              mem_rw;
  logic [7:0]        mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req, req_rw, req_lock, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req, req_rw, req_lock, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_rw, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rtl/mem_bus_arbiter_rr_pick.sv - round-robin winner search starting after the last winner
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [NREQ-1:0] win_oh,
  output logic [2:0]      win_idx
);

  logic [7:0] req8;
  logic [3:0] pos;
  logic       found;

  assign req8 = 8'(req);

  // Scan last+1, last+2, ... with wrap; first set bit wins.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = {1'b0, last} + 4'(k);
      if (pos >= 4'(NREQ)) pos = pos - 4'(NREQ);
      if (!found && req8[pos[2:0]]) begin
        found   = 1'b1;
        win_idx = pos[2:0];
      end
    end
    win_oh = NREQ'(8'd1 << win_idx);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the 8-bit memory bus between NREQ requesters
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MEM_LAT = 1,
  parameter int PRIO0   = 0
) (
  input  logic            clk,
  input  logic            rst,
  mem_bus_arbiter_if.slave bus
);

  arb_state_t      state_q, state_d;
  logic [2:0]      last_q, last_d;
  logic [2:0]      owner_q, owner_d;
  logic            lock_q, lock_d;
  logic [2:0]      w_q, w_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_rw_q, mem_rw_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;

  logic [7:0]      req8, rw8, lock8;
  logic [NREQ-1:0] rr_oh;
  logic [2:0]      rr_idx;
  logic            owner_req;
  logic            use_prio;
  logic [2:0]      sel;

  assign req8  = 8'(bus.req);
  assign rw8   = 8'(bus.req_rw);
  assign lock8 = 8'(bus.req_lock);

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req     (bus.req),
    .last    (last_q),
    .win_oh  (rr_oh),
    .win_idx (rr_idx)
  );

  // Winner priority: live lock owner, then requester 0 when prioritised, then round-robin.
  always_comb begin
    owner_req = lock_q && req8[owner_q];
    use_prio  = (PRIO0 != 0) && bus.req[0];
    if (owner_req)     sel = owner_q;
    else if (use_prio) sel = 3'd0;
    else               sel = rr_idx;
  end

  // Next-state and next registered-output computation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (lock_q && !req8[owner_q]) lock_d = 1'b0;
        if (|bus.req) begin
          w_d         = sel;
          mem_en_d    = 1'b1;
          mem_rw_d    = rw8[sel];
          mem_addr_d  = get_byte(64'(bus.req_addr), sel);
          mem_wdata_d = get_byte(64'(bus.req_wdata), sel);
          if (owner_req || use_prio) begin
            gnt_d = NREQ'(8'd1 << sel);
          end else begin
            gnt_d  = rr_oh;
            last_d = rr_idx;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (lock8[w_q]) begin
          lock_d  = 1'b1;
          owner_d = w_q;
        end else begin
          lock_d = 1'b0;
        end
        if (mem_rw_q == RW_READ) begin
          cnt_d   = 2'(MEM_LAT - 1);
          state_d = RDWAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RDWAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d  = bus.mem_rdata;
          rvalid_d = NREQ'(8'd1 << w_q);
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 3'(NREQ - 1);
      owner_q     <= '0;
      lock_q      <= 1'b0;
      w_q         <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.NREQ(3)) bus_a ();
  mem_bus_arbiter_if #(.NREQ(3)) bus_b ();

  mem_bus_arbiter #(.NREQ(3), .MEM_LAT(2), .PRIO0(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_bus_arbiter #(.NREQ(3), .MEM_LAT(1), .PRIO0(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // Memory model for instance a: data valid exactly MEM_LAT=2 cycles after the mem_en cycle.
  logic [7:0] mem_a [256];
  logic [1:0] rd_pipe = 2'b00;
  logic [7:0] rd_addr0 = 8'h00;
  logic [7:0] rd_addr1 = 8'h00;

  always @(posedge clk) begin
    rd_pipe  <= {rd_pipe[0], bus_a.mem_en && !bus_a.mem_rw};
    rd_addr0 <= bus_a.mem_addr;
    rd_addr1 <= rd_addr0;
  end

  assign bus_a.mem_rdata = rd_pipe[1] ? mem_a[rd_addr1] : 8'hEE;
  assign bus_b.mem_rdata = 8'h00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.req = '0; bus_a.req_rw = '0; bus_a.req_lock = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req = '0; bus_b.req_rw = '0; bus_b.req_lock = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    rst = 1'b0;
    step();
    step();
    tests++; if (bus_a.gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt: got %b want 000", bus_a.gnt); end
    tests++; if (bus_a.rvalid !== 3'b000) begin fails++; $display("FAIL reset_rvalid: got %b want 000", bus_a.rvalid); end
    tests++; if (bus_a.rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h want 00", bus_a.rdata); end
    tests++; if (bus_a.mem_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en: got %b want 0", bus_a.mem_en); end
    tests++; if (bus_a.mem_rw !== 1'b0) begin fails++; $display("FAIL reset_mem_rw: got %b want 0", bus_a.mem_rw); end
    tests++; if (bus_a.mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr: got %h want 00", bus_a.mem_addr); end
    tests++; if (bus_a.mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata: got %h want 00", bus_a.mem_wdata); end
    tests++; if (bus_b.gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt_b: got %b want 000", bus_b.gnt); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    bus_a.req = 3'b001; bus_a.req_rw = 3'b001;
    bus_a.req_addr = {8'h00, 8'h00, 8'h10}; bus_a.req_wdata = {8'h00, 8'h00, 8'hA5};
    step();
    tests++; if (bus_a.gnt !== 3'b001) begin fails++; $display("FAIL wr_gnt: got %b want 001", bus_a.gnt); end
    tests++; if (bus_a.mem_en !== 1'b1) begin fails++; $display("FAIL wr_mem_en: got %b want 1", bus_a.mem_en); end
    tests++; if (bus_a.mem_rw !== 1'b1) begin fails++; $display("FAIL wr_mem_rw: got %b want 1", bus_a.mem_rw); end
    tests++; if (bus_a.mem_addr !== 8'h10) begin fails++; $display("FAIL wr_mem_addr: got %h want 10", bus_a.mem_addr); end
    tests++; if (bus_a.mem_wdata !== 8'hA5) begin fails++; $display("FAIL wr_mem_wdata: got %h want a5", bus_a.mem_wdata); end
    bus_a.req = 3'b000;
    step();
    tests++; if (bus_a.gnt !== 3'b000 || bus_a.mem_en !== 1'b0) begin fails++; $display("FAIL wr_idle: gnt %b mem_en %b want 000 0", bus_a.gnt, bus_a.mem_en); end
  endtask

  task automatic test_single_read();
    bus_a.req = 3'b100; bus_a.req_rw = 3'b000;
    bus_a.req_addr = {8'h20, 8'h77, 8'h66};
    step();
    tests++; if (bus_a.gnt !== 3'b100) begin fails++; $display("FAIL rd_gnt: got %b want 100", bus_a.gnt); end
    tests++; if (bus_a.mem_en !== 1'b1 || bus_a.mem_rw !== 1'b0 || bus_a.mem_addr !== 8'h20) begin
      fails++; $display("FAIL rd_mem: en %b rw %b addr %h want 1 0 20", bus_a.mem_en, bus_a.mem_rw, bus_a.mem_addr);
    end
    bus_a.req = 3'b000;
    for (int c = 2; c <= 5; c++) begin
      step();
      if (c == 4) begin
        tests++; if (bus_a.rvalid !== 3'b100) begin fails++; $display("FAIL rd_rvalid_c4: got %b want 100", bus_a.rvalid); end
        tests++; if (bus_a.rdata !== 8'h3C) begin fails++; $display("FAIL rd_rdata_c4: got %h want 3c", bus_a.rdata); end
      end else begin
        tests++; if (bus_a.rvalid !== 3'b000) begin fails++; $display("FAIL rd_rvalid_c%0d: got %b want 000", c, bus_a.rvalid); end
      end
    end
    tests++; if (bus_a.rdata !== 8'h3C) begin fails++; $display("FAIL rd_rdata_hold: got %h want 3c", bus_a.rdata); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [8];
    logic [7:0] exp_a [8];
    exp_g = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    exp_a = '{8'h40, 8'h00, 8'h41, 8'h00, 8'h42, 8'h00, 8'h40, 8'h00};
    bus_a.req = 3'b111; bus_a.req_rw = 3'b111;
    bus_a.req_addr = {8'h42, 8'h41, 8'h40}; bus_a.req_wdata = {8'h03, 8'h02, 8'h01};
    for (int c = 1; c <= 8; c++) begin
      step();
      tests++; if (bus_a.gnt !== exp_g[c-1]) begin fails++; $display("FAIL rr_gnt_c%0d: got %b want %b", c, bus_a.gnt, exp_g[c-1]); end
      if (exp_g[c-1] != 3'b000) begin
        tests++; if (bus_a.mem_addr !== exp_a[c-1]) begin fails++; $display("FAIL rr_addr_c%0d: got %h want %h", c, bus_a.mem_addr, exp_a[c-1]); end
      end
      if (c == 7) bus_a.req = 3'b000;
    end
  endtask

  task automatic test_lock();
    logic [2:0] exp_g [9];
    exp_g = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    bus_a.req = 3'b010; bus_a.req_rw = 3'b111; bus_a.req_lock = 3'b010;
    for (int c = 1; c <= 9; c++) begin
      step();
      tests++; if (bus_a.gnt !== exp_g[c-1]) begin fails++; $display("FAIL lock_gnt_c%0d: got %b want %b", c, bus_a.gnt, exp_g[c-1]); end
      case (c)
        1: bus_a.req = 3'b111;
        4: bus_a.req_lock = 3'b000;
        5: bus_a.req = 3'b101;
        7: bus_a.req = 3'b001;
        9: bus_a.req = 3'b000;
        default: ;
      endcase
    end
    step();
  endtask

  task automatic test_prio0();
    bus_b.req = 3'b110; bus_b.req_rw = 3'b111;
    bus_b.req_addr = {8'h52, 8'h51, 8'h50};
    step();
    tests++; if (bus_b.gnt !== 3'b010) begin fails++; $display("FAIL prio_gnt_c1: got %b want 010", bus_b.gnt); end
    bus_b.req = 3'b101;
    step();
    tests++; if (bus_b.gnt !== 3'b000) begin fails++; $display("FAIL prio_gnt_c2: got %b want 000", bus_b.gnt); end
    step();
    tests++; if (bus_b.gnt !== 3'b001) begin fails++; $display("FAIL prio_gnt_c3: got %b want 001", bus_b.gnt); end
    tests++; if (bus_b.mem_addr !== 8'h50) begin fails++; $display("FAIL prio_addr_c3: got %h want 50", bus_b.mem_addr); end
    bus_b.req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid_read();
    bus_a.req = 3'b100; bus_a.req_rw = 3'b000; bus_a.req_lock = 3'b000;
    bus_a.req_addr = {8'h20, 8'h00, 8'h00};
    step();
    tests++; if (bus_a.gnt !== 3'b100) begin fails++; $display("FAIL rst_rd_gnt: got %b want 100", bus_a.gnt); end
    bus_a.req = 3'b000;
    step();
    rst = 1'b0;
    #1;
    tests++; if (bus_a.gnt !== 3'b000 || bus_a.rvalid !== 3'b000) begin fails++; $display("FAIL rst_mid_pulses: gnt %b rvalid %b want 000 000", bus_a.gnt, bus_a.rvalid); end
    tests++; if (bus_a.rdata !== 8'h00) begin fails++; $display("FAIL rst_mid_rdata: got %h want 00", bus_a.rdata); end
    tests++; if (bus_a.mem_en !== 1'b0 || bus_a.mem_addr !== 8'h00) begin fails++; $display("FAIL rst_mid_mem: en %b addr %h want 0 00", bus_a.mem_en, bus_a.mem_addr); end
    #2;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      tests++; if (bus_a.rvalid !== 3'b000) begin fails++; $display("FAIL rst_no_rvalid_%0d: got %b want 000", c, bus_a.rvalid); end
    end
    bus_a.req = 3'b001; bus_a.req_rw = 3'b001;
    bus_a.req_addr = {8'h00, 8'h00, 8'h33};
    step();
    tests++; if (bus_a.gnt !== 3'b001) begin fails++; $display("FAIL post_rst_gnt: got %b want 001", bus_a.gnt); end
    tests++; if (bus_a.mem_addr !== 8'h33) begin fails++; $display("FAIL post_rst_addr: got %h want 33", bus_a.mem_addr); end
    bus_a.req = 3'b000;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 8'(i);
    mem_a[8'h20] = 8'h3C;
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_lock();
    test_prio0();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit external memory bus (addr, data, rw) between NREQ requesters: core fetch/data port, DMA loader and debug port.
- Round-robin arbitration, with an optional fixed high priority for requester 0 and lock support for multi-byte transfers.
- Registered memory-side outputs; read data is returned with a per-requester valid pulse.
- Sits between the requesters and the memory macro.

Parameters:
- NREQ, 3, number of requesters (2..8).
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata (1..4).
- PRIO0, 0, 1 = requester 0 always wins when requesting; 0 = pure round-robin.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- req  input  NREQ  access request, one bit per requester
- req_rw  input  NREQ  per-requester direction, 1 = write, 0 = read
- req_lock  input  NREQ  hold the bus for the next access of the same requester
- req_addr  input  8*NREQ  packed addresses, requester i at [8i+7:8i]
- req_wdata  input  8*NREQ  packed write data
- gnt  output  NREQ  one-hot, 1-cycle grant pulse
- rvalid  output  NREQ  one-hot, 1-cycle read-data-valid pulse
- rdata  output  8  read data, valid while any rvalid bit is high
- mem_en  output  1  memory access strobe
- mem_rw  output  1  1 = write, 0 = read
- mem_addr  output  8  memory address
- mem_wdata  output  8  memory write data
- mem_rdata  input  8  memory read data

Behaviour:
- Reset (async, rst=0): all outputs 0; state=IDLE; rr pointer last=NREQ-1, so requester 0 wins first; lock owner cleared; wait counter 0.
- States: IDLE, ACCESS, RDWAIT.
- IDLE: if req != 0, pick winner w and capture req_rw[w], req_addr[w], req_wdata[w] into the mem_* registers.
  - Next state ACCESS.
  - Otherwise stay in IDLE with mem_en=0.
- Winner selection order:
  - (a) lock owner, if locked and req[owner]=1;
  - (b) requester 0, if PRIO0=1 and req[0]=1;
  - (c) first set req bit scanning last+1, last+2, ... with wrap at NREQ-1 to 0.
  - last is updated to w only for case (c).
- ACCESS (exactly 1 cycle): mem_en=1 and gnt[w]=1.
  - Write: next state IDLE.
  - Read: counter loaded with MEM_LAT-1; next state RDWAIT.
- RDWAIT: counter decrements each cycle. On the cycle the counter reads 0, rdata <= mem_rdata is registered, and in the following cycle rvalid[w]=1 for 1 cycle, then IDLE.
- Latency, request in IDLE at cycle 0:
  - gnt and mem_en at cycle 1.
  - Write completes at cycle 1; next arbitration at cycle 2.
  - Read rvalid at cycle 2+MEM_LAT.
- Requester protocol: hold req, req_rw, req_addr, req_wdata stable until gnt. Deasserting req in the capture cycle does not cancel the access; it still completes.
- Lock:
  - req_lock[w] sampled in ACCESS; if 1, w becomes lock owner.
  - The lock is released when the owner's access completes with req_lock=0, or when the owner is not requesting at arbitration.
  - While locked, other requesters starve.
- Simultaneous requests: exactly one gnt bit per access; gnt and rvalid are never multi-hot.
- rdata holds its last value when rvalid=0.
- Reset asserted mid-access: the transfer is abandoned; no rvalid is produced after reset release.
- Invalid req_addr/req_wdata on non-winners is ignored.

Decomposition:
- Package mem_arb_pkg:
  - state encoding IDLE=2'd0, ACCESS=2'd1, RDWAIT=2'd2;
  - RW_READ=1'b0, RW_WRITE=1'b1;
  - function to extract byte i from a packed bus.
- Sub-module rr_pick: combinational; inputs req and last; outputs one-hot winner and its index. Instantiated once. Lock and PRIO0 overrides are applied in the parent.

Test Plan:
- Single write: req=3'b001, rw=1, addr=8'h10, wdata=8'hA5 -> cycle 1: gnt=3'b001, mem_en=1, mem_rw=1, mem_addr=8'h10, mem_wdata=8'hA5; idle cycle 2.
- Single read, MEM_LAT=2, mem_rdata=8'h3C, requester 2, addr=8'h20 -> gnt[2] at cycle 1; rvalid=3'b100 with rdata=8'h3C at cycle 4.
- Round-robin, req=3'b111 held, writes -> grant order 0, 1, 2, 0 on cycles 1, 3, 5, 7.
- Lock: requester 1 with req_lock=1 for three writes while req[0] and req[2] are held -> gnt[1] three times consecutively; then requester 2 is granted, then requester 0.
- PRIO0=1, req=3'b110 followed by req[0] rising during requester 1's ACCESS -> the next grant goes to requester 0, not requester 2.
- Reset pulse during RDWAIT -> all outputs 0 immediately; no rvalid after release; first post-reset request from requester 0 granted at cycle 1.
